// File: rtl/sbus_mem_ctl.sv
// sbus_mem_ctl: S-bus memory slave with a 256 x 36 word array.
//
// Accepts one quadword-style request per start on phase A or phase B. It
// acknowledges the request, then returns the read words or accepts the write
// words one at a time, in rotating order, with an idle cycle between words.
//
// Ports
//   clk           sole clock, rising edge
//   RESET_n       asynchronous active-low reset
//   START_A/B     memory start on phase A / B
//   RQ[0:3]       word request mask, bit n = word n of the quadword
//   RD_RQ/WR_RQ   cycle type
//   ADR[14:35]    word address: [14:27] module select, [28:33] row, [34:35] first word
//   ADR_PAR       odd parity over ADR, RQ, RD_RQ, WR_RQ
//   DATA_IN       write data
//   DATA_OUT      read data, zero except while a read word is strobed
//   ACKN_A/B      one-cycle acknowledge on the starting phase
//   DATA_VALID_A/B one-cycle word strobe on the starting phase
//   BUSY          high whenever the controller is not idle
//   ADR_PAR_ERR   sticky address parity error
//
// Optional feature: define SBUS_MEM_PAR_CHK_EN to reject starts with bad
// address parity and flag them on ADR_PAR_ERR. Without it ADR_PAR is unused
// and ADR_PAR_ERR is tied low.
//
// state | meaning
// IDLE  | waiting for an accepted start
// ACK   | ACKN on the latched phase
// WAIT  | read access latency after ACK
// XFER  | one word strobed (read data out / write data in)
// GAP   | one idle cycle between words
module sbus_mem_ctl #(
    parameter int          ACC_LAT = 3,
    parameter logic [13:0] BASE    = 14'h0000
) (
    input  logic         clk,
    input  logic         RESET_n,
    input  logic         START_A,
    input  logic         START_B,
    input  logic [0:3]   RQ,
    input  logic         RD_RQ,
    input  logic         WR_RQ,
    input  logic [14:35] ADR,
    input  logic         ADR_PAR,
    input  logic [0:35]  DATA_IN,
    output logic [0:35]  DATA_OUT,
    output logic         ACKN_A,
    output logic         ACKN_B,
    output logic         DATA_VALID_A,
    output logic         DATA_VALID_B,
    output logic         BUSY,
    output logic         ADR_PAR_ERR
);

    typedef enum logic [2:0] {IDLE, ACK, WAIT, XFER, GAP} state_t;

    // WAIT lasts WAIT_LOAD+1 cycles, i.e. ACC_LAT-1; ACC_LAT==1 skips WAIT.
    localparam logic [3:0] WAIT_LOAD = (ACC_LAT > 1) ? 4'(ACC_LAT - 2) : 4'd0;

    state_t      state, state_nxt;
    logic [35:0] mem [0:255];
    logic [5:0]  row_q;
    logic [1:0]  word_q;
    logic [0:3]  rem_q;
    logic        rd_q;
    logic        ph_b_q;
    logic [3:0]  wait_cnt;
    logic        start_one;
    logic        par_ok;
    logic        accept;
    logic [0:3]  rem_clr;

    // First word at or after 'from' (mod 4) whose mask bit is set.
    function automatic logic [1:0] next_word(input logic [0:3] mask, input logic [1:0] from);
        logic [1:0] w;
        next_word = from;
        for (int i = 3; i >= 0; i--) begin
            w = from + 2'(i);
            if (mask[w]) next_word = w;
        end
    endfunction

    assign start_one = START_A ^ START_B;

`ifdef SBUS_MEM_PAR_CHK_EN
    assign par_ok = ^{ADR, RQ, RD_RQ, WR_RQ, ADR_PAR};
`else
    logic unused_adr_par;
    assign unused_adr_par = ADR_PAR;
    assign par_ok         = 1'b1;
`endif

    assign accept = start_one && (ADR[14:27] == BASE) && (RD_RQ ^ WR_RQ) && (|RQ) && par_ok;

    always_comb begin
        rem_clr         = rem_q;
        rem_clr[word_q] = 1'b0;
    end

    always_comb begin
        state_nxt    = state;
        BUSY         = (state != IDLE);
        ACKN_A       = 1'b0;
        ACKN_B       = 1'b0;
        DATA_VALID_A = 1'b0;
        DATA_VALID_B = 1'b0;
        DATA_OUT     = '0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = ACK;
            end
            ACK: begin
                ACKN_A = !ph_b_q;
                ACKN_B = ph_b_q;
                if (!rd_q || (ACC_LAT <= 1)) state_nxt = XFER;
                else                         state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_cnt == 4'd0) state_nxt = XFER;
            end
            XFER: begin
                DATA_VALID_A = !ph_b_q;
                DATA_VALID_B = ph_b_q;
                if (rd_q) DATA_OUT = mem[{row_q, word_q}];
                state_nxt = (|rem_clr) ? GAP : IDLE;
            end
            GAP: begin
                state_nxt = XFER;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state    <= IDLE;
            row_q    <= '0;
            word_q   <= '0;
            rem_q    <= '0;
            rd_q     <= 1'b0;
            ph_b_q   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        row_q  <= ADR[28:33];
                        word_q <= next_word(RQ, ADR[34:35]);
                        rem_q  <= RQ;
                        rd_q   <= RD_RQ;
                        ph_b_q <= START_B;
                    end
                end
                ACK:  wait_cnt <= WAIT_LOAD;
                WAIT: if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                XFER: begin
                    rem_q  <= rem_clr;
                    word_q <= next_word(rem_clr, word_q + 2'd1);
                end
                default: ;
            endcase
        end
    end

    // Array is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (state == XFER && !rd_q) mem[{row_q, word_q}] <= DATA_IN;
    end

`ifdef SBUS_MEM_PAR_CHK_EN
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n)                                   ADR_PAR_ERR <= 1'b0;
        else if (state == IDLE && start_one && !par_ok) ADR_PAR_ERR <= 1'b1;
    end
`else
    assign ADR_PAR_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_sbus_mem_ctl.sv
// Bench for sbus_mem_ctl: a per-cycle expectation schedule built from the
// request rules (acceptance, latency, rotating word order, one-cycle gaps)
// is compared against every output on every falling edge, plus literal
// expectations for the documented scenarios.
module tb_sbus_mem_ctl;
    localparam int          ACC_LAT = 3;
    localparam logic [13:0] BASE    = 14'h0123;
    localparam int          MAXC    = 4096;
`ifdef SBUS_MEM_PAR_CHK_EN
    localparam bit PAR_CHK = 1'b1;
`else
    localparam bit PAR_CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         RESET_n;
    logic         START_A, START_B, RD_RQ, WR_RQ, ADR_PAR;
    logic [0:3]   RQ;
    logic [14:35] ADR;
    logic [0:35]  DATA_IN, DATA_OUT;
    logic         ACKN_A, ACKN_B, DATA_VALID_A, DATA_VALID_B, BUSY, ADR_PAR_ERR;

    sbus_mem_ctl #(.ACC_LAT(ACC_LAT), .BASE(BASE)) dut (
        .clk(clk), .RESET_n(RESET_n), .START_A(START_A), .START_B(START_B),
        .RQ(RQ), .RD_RQ(RD_RQ), .WR_RQ(WR_RQ), .ADR(ADR), .ADR_PAR(ADR_PAR),
        .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .ACKN_A(ACKN_A), .ACKN_B(ACKN_B),
        .DATA_VALID_A(DATA_VALID_A), .DATA_VALID_B(DATA_VALID_B), .BUSY(BUSY),
        .ADR_PAR_ERR(ADR_PAR_ERR));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs per cycle index.
    bit          e_ack_a[MAXC], e_ack_b[MAXC], e_dv_a[MAXC], e_dv_b[MAXC], e_busy[MAXC];
    bit   [35:0] e_dout[MAXC];
    logic [35:0] mem_m[256];
    int          busy_until = -1;
    int          perr_cyc   = -1;
    int          pw_c[$];
    int          pw_i[$];
    logic [35:0] pw_d[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Observation log for literal checks.
    int          n_ack_a, n_ack_b, n_dv_a, n_dv_b, n_busy, ack_cyc;
    int          dv_cyc[$];
    logic [35:0] dv_dat[$];

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    // Schedule what a start issued during cycle k must produce.
    function automatic void model_start(int k, bit a, bit b, logic [0:3] rq, bit rd, bit wr,
                                        logic [13:0] tag, logic [5:0] row, logic [1:0] w0,
                                        logic [35:0] din, bit par_good);
        bit ok;
        int t, c, w;
        ok = (a ^ b) && (tag == BASE) && (rd ^ wr) && (rq != 4'b0000) && (k > busy_until);
        if (PAR_CHK && (a ^ b) && !par_good && (k > busy_until) && perr_cyc < 0) perr_cyc = k + 1;
        ok = ok && (par_good || !PAR_CHK);
        if (!ok) return;
        t = k + 1;
        if (a) e_ack_a[t] = 1'b1; else e_ack_b[t] = 1'b1;
        c = rd ? t + ACC_LAT : t + 1;
        for (int i = 0; i < 4; i++) begin
            w = (int'(w0) + i) % 4;
            if (rq[w]) begin
                if (a) e_dv_a[c] = 1'b1; else e_dv_b[c] = 1'b1;
                if (rd) e_dout[c] = mem_m[row * 4 + w];
                else begin
                    pw_c.push_back(c); pw_i.push_back(row * 4 + w); pw_d.push_back(din);
                end
                c += 2;
            end
        end
        busy_until = c - 2;
        for (int j = t; j <= busy_until; j++) e_busy[j] = 1'b1;
    endfunction

    function automatic void model_reset(int r);
        for (int c = r; c < MAXC; c++) begin
            e_ack_a[c] = 0; e_ack_b[c] = 0; e_dv_a[c] = 0; e_dv_b[c] = 0;
            e_busy[c] = 0; e_dout[c] = '0;
        end
        if (busy_until >= r) busy_until = r - 1;
        perr_cyc = -1;
        while (pw_c.size() > 0 && pw_c[$] >= r) begin
            void'(pw_c.pop_back()); void'(pw_i.pop_back()); void'(pw_d.pop_back());
        end
    endfunction

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            chk("ackn_a", ACKN_A, e_ack_a[cyc]);
            chk("ackn_b", ACKN_B, e_ack_b[cyc]);
            chk("dv_a", DATA_VALID_A, e_dv_a[cyc]);
            chk("dv_b", DATA_VALID_B, e_dv_b[cyc]);
            chk("busy", BUSY, e_busy[cyc]);
            chk("data_out", DATA_OUT, e_dout[cyc]);
            chk("par_err", ADR_PAR_ERR, (perr_cyc >= 0 && cyc >= perr_cyc));
        end
        while (pw_c.size() > 0 && pw_c[0] <= cyc) begin
            mem_m[pw_i[0]] = pw_d[0];
            void'(pw_c.pop_front()); void'(pw_i.pop_front()); void'(pw_d.pop_front());
        end
        if (ACKN_A) begin n_ack_a++; ack_cyc = cyc; end
        if (ACKN_B) begin n_ack_b++; ack_cyc = cyc; end
        if (DATA_VALID_A) n_dv_a++;
        if (DATA_VALID_B) n_dv_b++;
        if (BUSY) n_busy++;
        if (DATA_VALID_A || DATA_VALID_B) begin
            dv_cyc.push_back(cyc);
            dv_dat.push_back(DATA_OUT);
        end
    end

    task automatic clear_log();
        n_ack_a = 0; n_ack_b = 0; n_dv_a = 0; n_dv_b = 0; n_busy = 0; ack_cyc = -1;
        dv_cyc.delete(); dv_dat.delete();
    endtask

    task automatic do_start(bit a, bit b, logic [0:3] rq, bit rd, bit wr, logic [13:0] tag,
                            logic [5:0] row, logic [1:0] w0, logic [35:0] din, bit par_good);
        @(posedge clk); #1;
        START_A = a; START_B = b; RQ = rq; RD_RQ = rd; WR_RQ = wr;
        ADR = {tag, row, w0}; DATA_IN = din;
        ADR_PAR = (~^{tag, row, w0, rq, rd, wr}) ^ !par_good;
        model_start(cyc, a, b, rq, rd, wr, tag, row, w0, din, par_good);
        @(posedge clk); #1;
        START_A = 0; START_B = 0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic pulse_reset(string nm);
        @(posedge clk); #2;
        RESET_n = 0;
        model_reset(cyc);
        #1;
        chk({nm, "_busy"}, BUSY, 0);
        chk({nm, "_ack"}, {ACKN_A, ACKN_B}, 0);
        chk({nm, "_dv"}, {DATA_VALID_A, DATA_VALID_B}, 0);
        chk({nm, "_dout"}, DATA_OUT, 0);
        chk({nm, "_perr"}, ADR_PAR_ERR, 0);
        repeat (2) @(posedge clk); #2;
        RESET_n = 1;
    endtask

    task automatic chk_data(string nm, logic [35:0] d0, logic [35:0] d1, logic [35:0] d2,
                            logic [35:0] d3, int n);
        logic [35:0] exp [4];
        exp = '{d0, d1, d2, d3};
        chk({nm, "_count"}, dv_dat.size(), n);
        if (dv_dat.size() == n)
            for (int i = 0; i < n; i++) chk({nm, "_word"}, dv_dat[i], exp[i]);
    endtask

    initial begin
        logic [0:3] oh;
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        START_A = 0; START_B = 0; RQ = '0; RD_RQ = 0; WR_RQ = 0; ADR = '0;
        ADR_PAR = 0; DATA_IN = '0; RESET_n = 0;
        clear_log();
        #12;
        chk("reset_busy", BUSY, 0);
        chk("reset_dout", DATA_OUT, 0);
        chk("reset_strobes", {ACKN_A, ACKN_B, DATA_VALID_A, DATA_VALID_B}, 0);
        idle(2); #2 RESET_n = 1;

        // Preload row 0x10 words 0..3 = 1..4 with single-word writes.
        for (int i = 0; i < 4; i++) begin
            oh = '0; oh[i] = 1'b1;
            do_start(1, 0, oh, 0, 1, BASE, 6'h10, 2'(i), 36'(i + 1), 1);
            idle(4);
        end

        // Quadword read starting at word 2.
        clear_log();
        do_start(1, 0, 4'b1111, 1, 0, BASE, 6'h10, 2'd2, '0, 1);
        idle(12);
        chk("q_ack_a", n_ack_a, 1);
        chk("q_ack_b", n_ack_b, 0);
        chk("q_dv_a", n_dv_a, 4);
        chk("q_dv_b", n_dv_b, 0);
        chk_data("q", 36'd3, 36'd4, 36'd1, 36'd2, 4);
        if (dv_cyc.size() >= 2) begin
            chk("q_latency", dv_cyc[0] - ack_cyc, 3);
            chk("q_spacing", dv_cyc[1] - dv_cyc[0], 2);
        end

        // Preload row 0x11 = 0x100..0x103, then sparse write on B.
        for (int i = 0; i < 4; i++) begin
            oh = '0; oh[i] = 1'b1;
            do_start(1, 0, oh, 0, 1, BASE, 6'h11, 2'(i), 36'h100 + 36'(i), 1);
            idle(4);
        end
        clear_log();
        do_start(0, 1, 4'b0101, 0, 1, BASE, 6'h11, 2'd3, 36'o777, 1);
        idle(8);
        chk("sw_ack_b", n_ack_b, 1);
        chk("sw_dv_b", n_dv_b, 2);
        chk("sw_dv_a", n_dv_a, 0);
        clear_log();
        do_start(0, 1, 4'b1111, 1, 0, BASE, 6'h11, 2'd0, '0, 1);
        idle(12);
        chk_data("sw_rb", 36'h100, 36'o777, 36'h102, 36'o777, 4);

        // Sparse read with wrap: from word 3, mask selects words 0 and 2.
        clear_log();
        do_start(0, 1, 4'b1010, 1, 0, BASE, 6'h10, 2'd3, '0, 1);
        idle(10);
        chk_data("wrap", 36'd1, 36'd3, 0, 0, 2);

        // Rejected starts.
        clear_log();
        do_start(1, 1, 4'b1111, 1, 0, BASE, 6'h10, 2'd0, '0, 1);     idle(4);
        do_start(1, 0, 4'b0000, 1, 0, BASE, 6'h10, 2'd0, '0, 1);     idle(4);
        do_start(1, 0, 4'b1111, 1, 0, BASE + 14'd1, 6'h10, 2'd0, '0, 1); idle(4);
        do_start(0, 1, 4'b1111, 1, 1, BASE, 6'h10, 2'd0, '0, 1);     idle(4);
        do_start(0, 1, 4'b1111, 0, 0, BASE, 6'h10, 2'd0, '0, 1);     idle(4);
        chk("rej_ack", n_ack_a + n_ack_b, 0);
        chk("rej_busy", n_busy, 0);

        // Start on B while an A read is in its latency wait.
        clear_log();
        do_start(1, 0, 4'b1111, 1, 0, BASE, 6'h10, 2'd0, '0, 1);
        do_start(0, 1, 4'b1111, 1, 0, BASE, 6'h11, 2'd0, '0, 1);
        idle(12);
        chk("busy_ack_b", n_ack_b, 0);
        chk("busy_dv_a", n_dv_a, 4);
        chk("busy_dv_b", n_dv_b, 0);
        chk_data("busy", 36'd1, 36'd2, 36'd3, 36'd4, 4);

        // Reset after the second word of a 4-word read.
        clear_log();
        do_start(1, 0, 4'b1111, 1, 0, BASE, 6'h10, 2'd0, '0, 1);
        for (int i = 0; i < 20 && dv_cyc.size() < 2; i++) @(posedge clk);
        chk("mid_two_dv_seen", dv_cyc.size() >= 2, 1);
        pulse_reset("mid_rst");
        idle(4);
        chk("mid_abort_dv", n_dv_a, 2);
        clear_log();
        do_start(0, 1, 4'b0100, 1, 0, BASE, 6'h10, 2'd1, '0, 1);
        idle(8);
        chk("post_rst_ack_b", n_ack_b, 1);
        chk_data("post_rst", 36'd2, 0, 0, 0, 1);

        // Bad address parity.
        clear_log();
        do_start(1, 0, 4'b1111, 1, 0, BASE, 6'h10, 2'd0, '0, 0);
        idle(12);
`ifdef SBUS_MEM_PAR_CHK_EN
        chk("par_ack", n_ack_a, 0);
        chk("par_err_set", ADR_PAR_ERR, 1);
        idle(3);
        chk("par_err_held", ADR_PAR_ERR, 1);
        pulse_reset("par_rst");
        idle(2);
        chk("par_err_clr", ADR_PAR_ERR, 0);
`else
        chk("par_ack", n_ack_a, 1);
        chk("par_err_tied", ADR_PAR_ERR, 0);
        chk_data("par_ign", 36'd1, 36'd2, 36'd3, 36'd4, 4);
`endif

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
